// File: rtl/mmio_hex_key_port.sv
// Memory-mapped seven-segment / key / switch port for the MIPS32 data bus.
// Six registered HEX digits, debounced KEY[1:0] with W1C sticky press flags, synchronised SW[9:0].
module mmio_hex_key_port #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        nce,
  input  logic        re,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  input  logic [1:0]  key,
  input  logic [9:0]  sw,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [23:0]      value_q, value_d;
  logic [5:0]       en_q, en_d;
  logic [5:0]       dp_q, dp_d;
  logic [1:0]       flags_q, flags_d;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       key_s1_q, key_s2_q;
  logic [9:0]       sw_s1_q, sw_s2_q;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [7:0]       hex_q [6];
  logic [7:0]       hex_d [6];
  logic [1:0]       clr;
  logic [1:0]       press;
  logic             wr;

  // Only d_in[23:0] carries register content; the top byte is dropped on write.
  logic unused_d_in;
  assign unused_d_in = &{1'b0, d_in[31:24]};

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  assign wr = !nce && we;

  always_comb begin
    value_d = value_q;
    en_d    = en_q;
    dp_d    = dp_q;
    clr     = 2'b00;
    if (wr) begin
      case (addr)
        2'd0: value_d = d_in[23:0];
        2'd1: begin
          en_d = d_in[5:0];
          dp_d = d_in[13:8];
        end
        2'd2: clr = d_in[5:4];
        default: ;
      endcase
    end
  end

  // A mismatch must persist for DEBOUNCE_CYCLES consecutive edges; any return resets the count.
  always_comb begin
    stable_d = stable_q;
    cnt0_d   = '0;
    cnt1_d   = '0;
    if (key_s2_q[0] != stable_q[0]) begin
      if (cnt0_q == CNT_MAX) stable_d[0] = key_s2_q[0];
      else                   cnt0_d      = cnt0_q + 1'b1;
    end
    if (key_s2_q[1] != stable_q[1]) begin
      if (cnt1_q == CNT_MAX) stable_d[1] = key_s2_q[1];
      else                   cnt1_d      = cnt1_q + 1'b1;
    end
    press   = stable_q & ~stable_d;
    flags_d = (flags_q & ~clr) | press;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_hex
      assign hex_d[gi] = en_q[gi] ? {~dp_q[gi], seg7(value_q[4*gi +: 4])} : 8'hFF;
    end
  endgenerate

  always_comb begin
    d_out = 32'h0;
    if (!nce && re) begin
      case (addr)
        2'd0: d_out = {8'h0, value_q};
        2'd1: d_out = {18'h0, dp_q, 2'b00, en_q};
        2'd2: d_out = {26'h0, flags_q, 2'b00, stable_q};
        default: d_out = {22'h0, sw_s2_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      value_q  <= '0;
      en_q     <= 6'h3F;
      dp_q     <= '0;
      flags_q  <= '0;
      stable_q <= 2'b11;
      key_s1_q <= 2'b11;
      key_s2_q <= 2'b11;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      for (int i = 0; i < 6; i++) hex_q[i] <= 8'hC0;
    end else begin
      value_q  <= value_d;
      en_q     <= en_d;
      dp_q     <= dp_d;
      flags_q  <= flags_d;
      stable_q <= stable_d;
      key_s1_q <= key;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule
